// File: rtl/ram_dp_banked_pkg.sv
// Shared RAM helpers: clog2-style sizing, a max macro, bank geometry and the
// clear-FSM state encoding used by the banked dual-port RAM.
`ifndef RAM_MAX
`define RAM_MAX(a, b) (((a) > (b)) ? (a) : (b))
`endif

package ram_dp_banked_pkg;

  // Geometry of one SB_RAM256x16 primitive.
  localparam int RAM_LANE_WIDTH = 16;
  localparam int RAM_BANK_DEPTH = 256;
  localparam int RAM_BANK_ABITS = 8;

  // Clear FSM encoding (one bit: idle or filling with zeros).
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/SB_RAM256x16.sv
// Behavioural equivalent of the iCE40 256x16 block RAM: registered read,
// bit-masked write (MASK bit = 1 keeps the stored bit). Reading and writing
// the same address on one edge returns the old word. Exclude this file when
// the vendor primitive library supplies the cell.
module SB_RAM256x16 (
  output logic [15:0] RDATA,
  input  logic        RCLK,
  input  logic        RCLKE,
  input  logic        RE,
  input  logic [7:0]  RADDR,
  input  logic        WCLK,
  input  logic        WCLKE,
  input  logic        WE,
  input  logic [7:0]  WADDR,
  input  logic [15:0] MASK,
  input  logic [15:0] WDATA
);

  logic [15:0] mem [256];

  // Masked write: only bits with MASK=0 take the new value.
  always_ff @(posedge WCLK) begin
    if (WCLKE && WE) begin
      mem[WADDR] <= (mem[WADDR] & MASK) | (WDATA & ~MASK);
    end
  end

  // Registered read; output holds when not enabled.
  always_ff @(posedge RCLK) begin
    if (RCLKE && RE) begin
      RDATA <= mem[RADDR];
    end
  end

endmodule

// File: rtl/ram_bank256.sv
// One 256-word bank: LANES primitives side by side, sharing address and
// RE/WE, each owning a 16-bit slice of data and mask. Primitives keep their
// default all-zero INIT contents.
module ram_bank256
  import ram_dp_banked_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      re_i,
  input  logic [RAM_BANK_ABITS-1:0] raddr_i,
  output logic [WORD_WIDTH-1:0]     rdata_o,
  input  logic                      we_i,
  input  logic [RAM_BANK_ABITS-1:0] waddr_i,
  input  logic [WORD_WIDTH-1:0]     wdata_i,
  input  logic [WORD_WIDTH-1:0]     mask_i
);

  localparam int LANES = WORD_WIDTH / RAM_LANE_WIDTH;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    SB_RAM256x16 u_ram (
      .RDATA (rdata_o[l*RAM_LANE_WIDTH +: RAM_LANE_WIDTH]),
      .RCLK  (clk_i),
      .RCLKE (1'b1),
      .RE    (re_i),
      .RADDR (raddr_i),
      .WCLK  (clk_i),
      .WCLKE (1'b1),
      .WE    (we_i),
      .WADDR (waddr_i),
      .MASK  (mask_i[l*RAM_LANE_WIDTH +: RAM_LANE_WIDTH]),
      .WDATA (wdata_i[l*RAM_LANE_WIDTH +: RAM_LANE_WIDTH])
    );
  end

endmodule

// File: rtl/ram_dp_banked.sv
// Banked simple dual-port RAM (one write port, one read port) built from
// 256x16 block RAMs, with 1-cycle read latency, same-address write-first
// forwarding, out-of-range handling and a zero-fill engine.
//
// Handshake: a request is taken on a rising edge when its enable (we_i/re_i)
// is high and busy_o is low; there is no backpressure. A taken read produces
// rvalid_o=1 for exactly the following cycle with rdata_o; rdata_o holds its
// last value otherwise. clear_i taken in idle starts a fill; busy_o is high
// for exactly VECTOR_LENGTH cycles, during which all requests are dropped.
module ram_dp_banked
  import ram_dp_banked_pkg::*;
#(
  parameter int VECTOR_LENGTH = 512,
  parameter int WORD_WIDTH    = 16,
  parameter int ADDR_WIDTH    = ceil_log2(VECTOR_LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  input  logic [WORD_WIDTH-1:0] mask_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  dbg_state_o
);

  localparam int BANKS  = VECTOR_LENGTH / RAM_BANK_DEPTH;
  localparam int BSEL_W = `RAM_MAX(ADDR_WIDTH - RAM_BANK_ABITS, 1);
  localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(VECTOR_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(VECTOR_LENGTH - 1);

  // Clear FSM
  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // Accepted user traffic
  logic user_ok, wr_in_range, rd_in_range, wr_acc, rd_acc;

  // Effective write port (user or zero-fill)
  logic                  we_eff;
  logic [ADDR_WIDTH-1:0] wa_eff;
  logic [WORD_WIDTH-1:0] wd_eff, wm_eff;
  logic [ADDR_WIDTH-1:0] wbank_sel, rbank_sel;

  // Read pipeline
  logic                  rvalid_q, rd_oor_q, fwd_hit_q;
  logic [BSEL_W-1:0]     rbank_q;
  logic [WORD_WIDTH-1:0] fwd_data_q, fwd_mask_q, rdata_hold_q;
  logic [WORD_WIDTH-1:0] bank_rdata [BANKS];
  logic [WORD_WIDTH-1:0] bank_word, rd_word;

  assign user_ok     = (state_q == ST_IDLE);
  assign wr_in_range = ({1'b0, waddr_i} < ADDR_LIMIT);
  assign rd_in_range = ({1'b0, raddr_i} < ADDR_LIMIT);
  assign wr_acc      = user_ok && we_i && wr_in_range;
  assign rd_acc      = user_ok && re_i;

  assign busy_o      = (state_q == ST_CLEAR);
  assign dbg_state_o = state_q;

  // Clear FSM state and fill counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: start a fill on clear_i, walk every address once, then stop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (clear_i) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Write port mux: the fill owns the port while clearing.
  always_comb begin
    we_eff = wr_acc;
    wa_eff = waddr_i;
    wd_eff = wdata_i;
    wm_eff = mask_i;
    if (state_q == ST_CLEAR) begin
      we_eff = 1'b1;
      wa_eff = cnt_q;
      wd_eff = '0;
      wm_eff = '0;
    end
  end

  assign wbank_sel = wa_eff >> RAM_BANK_ABITS;
  assign rbank_sel = raddr_i >> RAM_BANK_ABITS;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    ram_bank256 #(
      .WORD_WIDTH (WORD_WIDTH)
    ) u_bank (
      .clk_i   (clk_i),
      .re_i    (rd_acc && rd_in_range && (rbank_sel == ADDR_WIDTH'(b))),
      .raddr_i (raddr_i[RAM_BANK_ABITS-1:0]),
      .rdata_o (bank_rdata[b]),
      .we_i    (we_eff && (wbank_sel == ADDR_WIDTH'(b))),
      .waddr_i (wa_eff[RAM_BANK_ABITS-1:0]),
      .wdata_i (wd_eff),
      .mask_i  (wm_eff)
    );
  end

  // Read-side registers: valid pulse, bank select, out-of-range flag,
  // forwarding capture, and the hold copy of the last delivered word.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rvalid_q     <= 1'b0;
      rd_oor_q     <= 1'b0;
      rbank_q      <= '0;
      fwd_hit_q    <= 1'b0;
      fwd_data_q   <= '0;
      fwd_mask_q   <= '0;
      rdata_hold_q <= '0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rd_oor_q   <= !rd_in_range;
        rbank_q    <= rbank_sel[BSEL_W-1:0];
        fwd_hit_q  <= wr_acc && (waddr_i == raddr_i);
        fwd_data_q <= wdata_i;
        fwd_mask_q <= mask_i;
      end
      if (rvalid_q) begin
        rdata_hold_q <= rd_word;
      end
    end
  end

  // Output word: bank mux, then write-first merge, then range override.
  always_comb begin
    bank_word = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (rbank_q == BSEL_W'(b)) begin
        bank_word = bank_rdata[b];
      end
    end
    rd_word = bank_word;
    if (fwd_hit_q) begin
      rd_word = (bank_word & fwd_mask_q) | (fwd_data_q & ~fwd_mask_q);
    end
    if (rd_oor_q) begin
      rd_word = '0;
    end
  end

  assign rdata_o  = rvalid_q ? rd_word : rdata_hold_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_ram_dp_banked.sv
// Bench for ram_dp_banked: a 1024x32 instance (main) and a 768x32 instance
// (out-of-range handling), both against a word-array reference model.
module tb_ram_dp_banked;

  localparam int VL   = 1024;
  localparam int VL_B = 768;
  localparam int WW   = 32;
  localparam int AW   = 10;

  // Clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Main instance
  logic          we_a, re_a, clr_a, rvalid_a, busy_a, st_a;
  logic [AW-1:0] waddr_a, raddr_a;
  logic [WW-1:0] wdata_a, mask_a, rdata_a;

  // 768-word instance
  logic          we_b, re_b, clr_b, rvalid_b, busy_b, st_b;
  logic [AW-1:0] waddr_b, raddr_b;
  logic [WW-1:0] wdata_b, mask_b, rdata_b;

  ram_dp_banked #(.VECTOR_LENGTH(VL), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .we_i(we_a), .waddr_i(waddr_a), .wdata_i(wdata_a),
    .mask_i(mask_a), .re_i(re_a), .raddr_i(raddr_a), .rdata_o(rdata_a),
    .rvalid_o(rvalid_a), .clear_i(clr_a), .busy_o(busy_a), .dbg_state_o(st_a)
  );

  ram_dp_banked #(.VECTOR_LENGTH(VL_B), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) u_dut_b (
    .clk_i(clk), .rstn_i(rstn), .we_i(we_b), .waddr_i(waddr_b), .wdata_i(wdata_b),
    .mask_i(mask_b), .re_i(re_b), .raddr_i(raddr_b), .rdata_o(rdata_b),
    .rvalid_o(rvalid_b), .clear_i(clr_b), .busy_o(busy_b), .dbg_state_o(st_b)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] exp_q_b[$];
  logic [WW-1:0] e_a, e_b;
  logic [WW-1:0] last_a = '0;

  // Reference model: plain word arrays; busy_left counts remaining fill cycles
  logic [WW-1:0] model_mem [VL];
  logic [WW-1:0] model_b   [VL_B];
  int busy_left = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor A: each cycle after the edge, rvalid must match the queue head.
  always @(posedge clk) begin
    #1;
    if (rstn) begin
      if (rvalid_a) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rvalid_a: got unexpected pulse, required none at %0t", $time);
        end else begin
          e_a = exp_q.pop_front();
          check("rdata_a", rdata_a, e_a);
          last_a = e_a;
        end
      end else if (exp_q.size() != 0) begin
        n_checks++; n_errors++;
        $display("FAIL rvalid_a: got 0, required 1 at %0t", $time);
        void'(exp_q.pop_front());
      end else begin
        check("rdata_hold_a", rdata_a, last_a);
      end
    end
  end

  // Monitor B
  always @(posedge clk) begin
    #1;
    if (rstn) begin
      if (rvalid_b) begin
        if (exp_q_b.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rvalid_b: got unexpected pulse, required none at %0t", $time);
        end else begin
          e_b = exp_q_b.pop_front();
          check("rdata_b", rdata_b, e_b);
        end
      end else if (exp_q_b.size() != 0) begin
        n_checks++; n_errors++;
        $display("FAIL rvalid_b: got 0, required 1 at %0t", $time);
        void'(exp_q_b.pop_front());
      end
    end
  end

  // Driver A: one cycle of stimulus, entered and left on a falling edge.
  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [WW-1:0] wd,
                     input logic [WW-1:0] wm, input logic re, input logic [AW-1:0] ra,
                     input logic clr);
    we_a = we; waddr_a = wa; wdata_a = wd; mask_a = wm;
    re_a = re; raddr_a = ra; clr_a = clr;
    if (busy_left > 0) begin
      // The k-th fill cycle zeroes address k-1; user traffic is dropped.
      model_mem[VL - busy_left] = '0;
      busy_left--;
    end else begin
      if (re) begin
        if (we && wa == ra) exp_q.push_back((wd & ~wm) | (model_mem[ra] & wm));
        else                exp_q.push_back(model_mem[ra]);
      end
      if (we) model_mem[wa] = (wd & ~wm) | (model_mem[wa] & wm);
      if (clr) busy_left = VL;
    end
    @(posedge clk);
    #1;
    check("busy_a", {31'b0, busy_a}, {31'b0, (busy_left > 0)});
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // Driver B (no mask, no clear)
  task automatic cyc_b(input logic we, input logic [AW-1:0] wa, input logic [WW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra);
    we_b = we; waddr_b = wa; wdata_b = wd; re_b = re; raddr_b = ra;
    if (re) exp_q_b.push_back((int'(ra) < VL_B) ? model_b[ra] : '0);
    if (we && int'(wa) < VL_B) model_b[wa] = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    logic [AW-1:0] wa, ra;
    logic [WW-1:0] wm;

    rstn = 1'b0;
    we_a = 0; re_a = 0; clr_a = 0; waddr_a = '0; raddr_a = '0; wdata_a = '0; mask_a = '0;
    we_b = 0; re_b = 0; clr_b = 0; waddr_b = '0; raddr_b = '0; wdata_b = '0; mask_b = '0;
    repeat (3) @(negedge clk);
    check("reset_rdata_a",  rdata_a, '0);
    check("reset_rvalid_a", {31'b0, rvalid_a}, '0);
    check("reset_busy_a",   {31'b0, busy_a}, '0);
    check("reset_rdata_b",  rdata_b, '0);
    check("reset_rvalid_b", {31'b0, rvalid_b}, '0);
    rstn = 1'b1;

    // 768-word instance: writes at/above 0x300 ignored, reads return 0
    cyc_b(1'b1, 10'h000, 32'h0BADF00D, 1'b0, '0);
    cyc_b(1'b1, 10'h100, 32'h5555AAAA, 1'b0, '0);
    cyc_b(1'b1, 10'h300, 32'hCAFEF00D, 1'b1, 10'h300);
    cyc_b(1'b0, '0, '0, 1'b1, 10'h000);
    cyc_b(1'b0, '0, '0, 1'b1, 10'h100);
    cyc_b(1'b1, 10'h3FF, 32'h13579BDF, 1'b1, 10'h300);
    cyc_b(1'b0, '0, '0, 1'b1, 10'h3FF);
    cyc_b(1'b0, '0, '0, 1'b1, 10'h2FF);
    cyc_b(1'b1, 10'h2FF, 32'h2468ACE0, 1'b0, '0);
    cyc_b(1'b0, '0, '0, 1'b1, 10'h2FF);
    cyc_b(1'b0, '0, '0, 1'b0, '0);
    cyc_b(1'b0, '0, '0, 1'b0, '0);

    // Back-to-back reads at both ends of the address space
    cyc(1'b1, 10'h000, 32'hDEADBEEF, '0, 1'b0, '0, 1'b0);
    cyc(1'b1, 10'h3FF, 32'h12345678, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'h000, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'h3FF, 1'b0);
    idle();

    // Masked write keeps upper half
    cyc(1'b1, 10'h155, 32'hFFFFFFFF, '0, 1'b0, '0, 1'b0);
    cyc(1'b1, 10'h155, 32'h00000000, 32'hFFFF0000, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'h155, 1'b0);
    idle();

    // Same-cycle read/write forwarding, then the stored result
    cyc(1'b1, 10'h200, 32'h11112222, '0, 1'b0, '0, 1'b0);
    cyc(1'b1, 10'h200, 32'hA5A5A5A5, 32'h0000FFFF, 1'b1, 10'h200, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'h200, 1'b0);
    idle();

    // Clear coincident with a write and a read; traffic during fill dropped
    cyc(1'b1, 10'h010, 32'h77777777, '0, 1'b1, 10'h000, 1'b1);
    busy_cnt = busy_a ? 1 : 0;
    for (int i = 0; i < 2000 && busy_left > 0; i++) begin
      cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, VL - 1)), $urandom, '0,
          1'($urandom_range(0, 1)), AW'($urandom_range(0, VL - 1)), 1'($urandom_range(0, 1)));
      if (busy_a) busy_cnt++;
    end
    check("busy_cycles", WW'(busy_cnt), WW'(VL));
    for (int a = 0; a < VL; a++) cyc(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
    idle();

    // Random traffic on a small address set to provoke collisions
    for (int i = 0; i < 400; i++) begin
      wa = AW'(($urandom_range(0, 3) << 8) | $urandom_range(0, 3));
      ra = AW'(($urandom_range(0, 3) << 8) | $urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       wm = '0;
        1:       wm = $urandom;
        default: wm = '1;
      endcase
      cyc(1'($urandom_range(0, 1)), wa, $urandom, wm, 1'($urandom_range(0, 1)), ra, 1'b0);
    end
    idle();
    idle();

    // Reset during a fill: low addresses cleared, high addresses kept
    cyc(1'b1, 10'd50,  32'h50505050, '0, 1'b0, '0, 1'b0);
    cyc(1'b1, 10'd900, 32'h90909090, '0, 1'b0, '0, 1'b0);
    cyc(1'b1, 10'd100, 32'h10010010, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'd100, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    repeat (100) idle();
    rstn = 1'b0;
    #1;
    check("abort_busy",   {31'b0, busy_a}, '0);
    check("abort_rvalid", {31'b0, rvalid_a}, '0);
    check("abort_rdata",  rdata_a, '0);
    exp_q.delete();
    busy_left = 0;
    last_a = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b0, '0, '0, '0, 1'b1, 10'd50, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'd900, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'd100, 1'b0);
    idle();
    idle();

    check("queue_a_drained", WW'(exp_q.size()), '0);
    check("queue_b_drained", WW'(exp_q_b.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
